// File: rtl/half_adder_pkg.sv
// Shared defaults and result type for the half adder block.
// No logic here; imported by the adder top and its result queue.
// Queue depth is fixed at two entries.
package half_adder_pkg;

  localparam int HA_WIDTH_DEF  = 1;
  localparam int HA_CNT_W_DEF  = 16;
  localparam int HA_FIFO_DEPTH = 2;

  // One queued result at the default operand width
  typedef struct packed {
    logic [HA_WIDTH_DEF-1:0] sum;
    logic [HA_WIDTH_DEF-1:0] carry;
  } ha_result_t;

endpackage

// File: rtl/ha_result_fifo.sv
// Two-entry in-order queue of half adder results.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: push_rdy is registered and drops when both entries are occupied.
module ha_result_fifo
  import half_adder_pkg::*;
#(
  parameter type T = ha_result_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_vld,
  output logic push_rdy,
  input  T     push_dat,
  output logic pop_vld,
  input  logic pop_rdy,
  output T     pop_dat
);

  T           r_mem [HA_FIFO_DEPTH];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_cnt;
  logic       r_not_full;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_nxt;

  assign w_push    = push_vld & r_not_full;
  assign w_pop     = pop_vld & pop_rdy;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);

  assign push_rdy = r_not_full;
  assign pop_vld  = (r_cnt != 2'd0);
  // An empty queue presents an all-zero head rather than stale storage
  assign pop_dat  = pop_vld ? r_mem[r_rd_ptr] : '0;

  // Storage is data-only; validity is tracked by r_cnt, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  // Pointers, occupancy and the look-ahead not-full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
      r_not_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt      <= w_cnt_nxt;
      r_not_full <= (w_cnt_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/half_adder.sv
// Bank of WIDTH independent half adders feeding a 2-entry result queue, plus statistics.
// Latency: result is at the queue head one cycle after the input transfer.
// Backpressure: in_ready is registered; it drops while the queue holds two results.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEF,
  parameter int CNT_W = HA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] carry_count
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  res_t             w_res;
  res_t             w_head;
  logic             w_push;
  logic             w_any_carry;
  logic [CNT_W-1:0] r_pair_cnt;
  logic [CNT_W-1:0] r_carry_cnt;

  // Bitwise half adders: no carry ripples between bit positions
  assign w_res.sum   = a ^ b;
  assign w_res.carry = a & b;
  assign w_any_carry = |w_res.carry;
  assign w_push      = in_valid & in_ready;

  ha_result_fifo #(
    .T (res_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (w_res),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (w_head)
  );

  assign sum   = w_head.sum;
  assign carry = w_head.carry;

  // Saturating statistics; clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair_cnt  <= '0;
      r_carry_cnt <= '0;
    end else if (clr_stats) begin
      r_pair_cnt  <= '0;
      r_carry_cnt <= '0;
    end else if (w_push) begin
      if (r_pair_cnt != CNT_MAX) begin
        r_pair_cnt <= r_pair_cnt + 1'b1;
      end
      if (w_any_carry && (r_carry_cnt != CNT_MAX)) begin
        r_carry_cnt <= r_carry_cnt + 1'b1;
      end
    end
  end

  assign pair_count  = r_pair_cnt;
  assign carry_count = r_carry_cnt;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: 4-bit instance against a queue-based reference model,
// plus a 1-bit / 2-bit-counter instance for counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [3:0] a, b, sum, carry;
  logic [15:0] pair_count, carry_count;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr;
  logic [0:0] s_a, s_b, s_sum, s_carry;
  logic [1:0] s_pair_count, s_carry_count;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [7:0] mq[$];
  bit         m_rdy     = 0;
  int         m_pairs   = 0;
  int         m_carries = 0;
  bit         m_in_x    = 0;

  half_adder #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
    .clr_stats(clr_stats), .pair_count(pair_count), .carry_count(carry_count)
  );

  half_adder #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum), .carry(s_carry),
    .clr_stats(s_clr), .pair_count(s_pair_count), .carry_count(s_carry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy     = 0;
    m_pairs   = 0;
    m_carries = 0;
    m_in_x    = 0;
  endtask

  // One rising edge of the reference: pop, push, stats, then readiness
  task automatic model_edge();
    bit         out_x;
    logic [3:0] s, c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    out_x  = (mq.size() > 0) && out_ready;
    m_in_x = in_valid && m_rdy;
    s = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    if (out_x) void'(mq.pop_front());
    if (m_in_x) mq.push_back({s, c});
    if (clr_stats) begin
      m_pairs   = 0;
      m_carries = 0;
    end else if (m_in_x) begin
      if (m_pairs < 65535) m_pairs++;
      if (c != 0 && m_carries < 65535) m_carries++;
    end
    m_rdy = mq.size() < 2;
  endtask

  task automatic check_outputs();
    logic [7:0] head;
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    chk("out_valid",   32'(out_valid),   32'(mq.size() > 0));
    chk("sum",         32'(sum),         32'(head[7:4]));
    chk("carry",       32'(carry),       32'(head[3:0]));
    chk("in_ready",    32'(in_ready),    32'(m_rdy));
    chk("pair_count",  32'(pair_count),  32'(m_pairs));
    chk("carry_count", 32'(carry_count), 32'(m_carries));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  logic       exp_s [4];
  logic       exp_c [4];
  logic [3:0] pa [3];
  logic [3:0] pb [3];
  int         idx;
  int         prev;
  int         e;

  initial begin
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b1};
    pa    = '{4'd3, 4'd5, 4'd9};
    pb    = '{4'd6, 4'd7, 4'd15};

    rst_n = 1'b1;
    in_valid = 0; out_ready = 0; clr_stats = 0; a = '0; b = '0;
    s_in_valid = 0; s_out_ready = 0; s_clr = 0; s_a = '0; s_b = '0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_release_rdy", 32'(in_ready), 32'd1);

    // four operand combinations, one result per cycle
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      a = 4'(i >> 1);
      b = 4'(i & 1);
      cyc();
      chk("tt_vld",   32'(out_valid), 32'd1);
      chk("tt_sum",   32'(sum[0]),    32'(exp_s[i]));
      chk("tt_carry", 32'(carry[0]),  32'(exp_c[i]));
    end
    in_valid = 0;
    cyc();

    // multi-bit example
    prev = m_carries;
    in_valid = 1; a = 4'b1100; b = 4'b1010;
    cyc();
    chk("wide_sum",   32'(sum),         32'(4'b0110));
    chk("wide_carry", 32'(carry),       32'(4'b1000));
    chk("wide_ccnt",  32'(carry_count), 32'(prev + 1));
    in_valid = 0;
    cyc();
    cyc();

    // fill with consumer stalled, then drain in order
    out_ready = 0;
    idx = 0;
    in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      a = pa[idx]; b = pb[idx];
      cyc();
      if (m_in_x) idx++;
    end
    chk("full_rdy",   32'(in_ready), 32'd0);
    chk("full_head",  32'(sum),      32'(4'd5));
    chk("full_carry", 32'(carry),    32'(4'd2));
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      if (idx < 3) begin
        in_valid = 1; a = pa[idx]; b = pb[idx];
      end else begin
        in_valid = 0;
      end
      cyc();
      if (m_in_x) idx++;
    end
    in_valid = 0;
    cyc();

    // simultaneous push and pop with one entry queued
    in_valid = 1; a = 4'd1; b = 4'd1;
    cyc();
    a = 4'd2; b = 4'd3;
    cyc();
    chk("pp_vld",   32'(out_valid), 32'd1);
    chk("pp_sum",   32'(sum),       32'(4'd1));
    chk("pp_carry", 32'(carry),     32'(4'd2));
    in_valid = 0;
    cyc();

    // counter saturation and clear precedence on the narrow instance
    s_out_ready = 1; s_in_valid = 1; s_a = 1'b1; s_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      e = (k > 3) ? 3 : k;
      chk("sat_pairs",   32'(s_pair_count),  32'(e));
      chk("sat_carries", 32'(s_carry_count), 32'(e));
    end
    s_clr = 1;
    cyc();
    chk("clr_pairs",   32'(s_pair_count),  32'd0);
    chk("clr_carries", 32'(s_carry_count), 32'd0);
    s_clr = 0; s_in_valid = 0;
    cyc();
    chk("clr_hold", 32'(s_pair_count), 32'd0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr_stats = ($urandom % 50) == 0;
      a = 4'($urandom);
      b = 4'($urandom);
      cyc();
    end
    in_valid = 0; clr_stats = 0; out_ready = 1;
    cyc();
    cyc();

    // asynchronous reset with two results queued
    out_ready = 0; in_valid = 1; a = 4'hF; b = 4'hF;
    cyc();
    a = 4'h6; b = 4'h3;
    cyc();
    in_valid = 0;
    chk("pre_rst_rdy", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_vld",   32'(out_valid),  32'd0);
    chk("rst_pairs", 32'(pair_count), 32'd0);
    chk("rst_sat",   32'(s_pair_count), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_rdy", 32'(in_ready), 32'd1);
    out_ready = 1; in_valid = 1; a = 4'h5; b = 4'h4;
    cyc();
    in_valid = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent 1-bit half adders (operand width).
REQ-002 Parameter CNT_W, default 16: width of statistics counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset; deassertion synchronous to clk.
REQ-005 in_valid  in  1  operand pair a/b valid.
REQ-006 in_ready  out  1  block can accept an operand pair; registered.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 out_valid  out  1  head result valid.
REQ-010 out_ready  in  1  consumer accepts head result.
REQ-011 sum  out  WIDTH  per-bit sum of head result.
REQ-012 carry  out  WIDTH  per-bit carry of head result.
REQ-013 clr_stats  in  1  synchronous clear of statistics counters.
REQ-014 pair_count  out  CNT_W  number of accepted operand pairs.
REQ-015 carry_count  out  CNT_W  number of accepted pairs with any carry bit set.

Function
REQ-016 Per bit i: sum[i] = a[i] XOR b[i], carry[i] = a[i] AND b[i]; no carry propagation between bits.
REQ-017 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-018 Accepted results enter a 2-entry in-order result queue; latency from input transfer edge to out_valid=1 with that result is 1 cycle.
REQ-019 in_ready = 1 when the queue holds fewer than 2 entries after the current edge's updates; never depends combinationally on out_ready.
REQ-020 Sustained throughput is one result per cycle when out_ready is held 1.
REQ-021 Push and pop on the same edge: occupancy unchanged, order preserved.
REQ-022 Queue full (2 entries): in_ready=0, in_valid ignored, no data loss.
REQ-023 Queue empty: out_valid=0, sum=0, carry=0.
REQ-024 While out_valid=1 and out_ready=0, sum, carry, out_valid remain stable.
REQ-025 a/b are sampled only at the input transfer edge; changes at other times have no effect.
REQ-026 pair_count increments by 1 per input transfer; carry_count increments by 1 per input transfer where (a AND b) != 0.
REQ-027 Counters saturate at 2^CNT_W-1.
REQ-028 clr_stats=1 zeroes both counters at the edge, taking precedence over a simultaneous increment.

Reset
REQ-029 rst_n=0 immediately forces: queue empty, out_valid=0, sum=0, carry=0, in_ready=0, pair_count=0, carry_count=0.
REQ-030 in_ready becomes 1 on the first rising edge after rst_n deasserts.
REQ-031 Reset mid-operation discards all queued results; no partial transfer completes.

Structure
REQ-032 Package half_adder_pkg holds the WIDTH/CNT_W defaults and typedef ha_result_t {sum, carry}.
REQ-033 One sub-module, ha_result_fifo: 2-entry ha_result_t queue with registered not-full flag; adder logic and counters live in half_adder.

Verification
REQ-034 WIDTH=1, out_ready=1; apply (a,b) = 00,01,10,11 on successive cycles -> results (sum,carry) = 00,10,10,01, each one cycle after acceptance.
REQ-035 WIDTH=4, a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000; carry_count increments by 1.
REQ-036 out_ready=0; present 3 pairs back-to-back -> 2 accepted, in_ready=0, head stable; raise out_ready -> results drain in order; third pair then accepted.
REQ-037 Queue holding 1 entry, simultaneous push and pop -> occupancy stays 1, out_valid stays 1, next result correct.
REQ-038 CNT_W=2; accept 5 pairs with a=b=1 -> both counters saturate at 3; clr_stats asserted together with a transfer -> both counters 0.
REQ-039 Assert rst_n=0 asynchronously with 2 queued results -> out_valid, sum, carry, counters 0 immediately; in_ready 1 one edge after release.
